// File: rtl/alu_req_arbiter_if.sv
// Requester, response and ALU-side signals shared by alu_req_arbiter and its environment.
// slave = arbiter side; master = requesters plus the ALU instance.
interface alu_req_arbiter_if #(
  parameter int WIDTH = 6
);
  logic             a_req_valid;
  logic             b_req_valid;
  logic             a_req_ready;
  logic             b_req_ready;
  logic [WIDTH-1:0] a_x;
  logic [WIDTH-1:0] a_y;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] b_y;
  logic [2:0]       a_fxn;
  logic [2:0]       b_fxn;
  logic             a_rsp_valid;
  logic             b_rsp_valid;
  logic             a_rsp_ready;
  logic             b_rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_overflow;
  logic             rsp_cout;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [2:0]       alu_fxn;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_overflow;
  logic             alu_cout;
  logic             busy;

  modport slave (
    input  a_req_valid, b_req_valid, a_x, a_y, b_x, b_y, a_fxn, b_fxn,
    input  a_rsp_ready, b_rsp_ready, alu_sum, alu_overflow, alu_cout,
    output a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid,
    output rsp_result, rsp_overflow, rsp_cout, alu_x, alu_y, alu_fxn, busy
  );

  modport master (
    output a_req_valid, b_req_valid, a_x, a_y, b_x, b_y, a_fxn, b_fxn,
    output a_rsp_ready, b_rsp_ready, alu_sum, alu_overflow, alu_cout,
    input  a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid,
    input  rsp_result, rsp_overflow, rsp_cout, alu_x, alu_y, alu_fxn, busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a shared combinational ALU.
// Define ALU_ARB_STATS_EN to add saturating operation/overflow counter ports.
module alu_req_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_req_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0] stat_a_ops,
  output logic [7:0] stat_b_ops,
  output logic [7:0] stat_ovf
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam int NP = 2;  // port 0 = A, port 1 = B

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_grant_reg, last_grant_next;
  logic [WIDTH-1:0] alu_x_reg, alu_y_reg;
  logic [2:0]       alu_fxn_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic             rsp_overflow_reg, rsp_cout_reg;

  logic [NP-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [WIDTH-1:0] op_x [NP];
  logic [WIDTH-1:0] op_y [NP];
  logic [2:0]       op_fxn [NP];
  logic             win;
  logic             load_op, cap_rsp;

  assign req_valid = {bus.b_req_valid, bus.a_req_valid};
  assign rsp_ready = {bus.b_rsp_ready, bus.a_rsp_ready};
  assign op_x[0]   = bus.a_x;
  assign op_x[1]   = bus.b_x;
  assign op_y[0]   = bus.a_y;
  assign op_y[1]   = bus.b_y;
  assign op_fxn[0] = bus.a_fxn;
  assign op_fxn[1] = bus.b_fxn;

  // Under contention the port that did not win last time goes first.
  always_comb begin
    win = req_valid[1];
    if (req_valid == 2'b11) begin
      win = ~last_grant_reg;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    req_ready       = '0;
    load_op         = 1'b0;
    cap_rsp         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready[win]  = 1'b1;
          owner_next      = win;
          last_grant_next = win;
          load_op         = 1'b1;
          state_next      = S_EXEC;
        end
      end
      S_EXEC: begin
        cap_rsp    = 1'b1;
        state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[owner_reg]) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      owner_reg        <= 1'b0;
      last_grant_reg   <= 1'b1;
      alu_x_reg        <= '0;
      alu_y_reg        <= '0;
      alu_fxn_reg      <= '0;
      rsp_result_reg   <= '0;
      rsp_overflow_reg <= 1'b0;
      rsp_cout_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      if (load_op) begin
        alu_x_reg   <= op_x[win];
        alu_y_reg   <= op_y[win];
        alu_fxn_reg <= op_fxn[win];
      end
      if (cap_rsp) begin
        rsp_result_reg   <= bus.alu_sum;
        rsp_overflow_reg <= bus.alu_overflow;
        rsp_cout_reg     <= bus.alu_cout;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_port
      assign rsp_valid[gi] = (state_reg == S_RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign bus.a_req_ready  = req_ready[0];
  assign bus.b_req_ready  = req_ready[1];
  assign bus.a_rsp_valid  = rsp_valid[0];
  assign bus.b_rsp_valid  = rsp_valid[1];
  assign bus.rsp_result   = rsp_result_reg;
  assign bus.rsp_overflow = rsp_overflow_reg;
  assign bus.rsp_cout     = rsp_cout_reg;
  assign bus.alu_x        = alu_x_reg;
  assign bus.alu_y        = alu_y_reg;
  assign bus.alu_fxn      = alu_fxn_reg;
  assign bus.busy         = (state_reg != S_IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [7:0] stat_a_reg, stat_b_reg, stat_ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_reg   <= '0;
      stat_b_reg   <= '0;
      stat_ovf_reg <= '0;
    end else begin
      if (req_ready[0] && (stat_a_reg != 8'hFF)) stat_a_reg <= stat_a_reg + 8'd1;
      if (req_ready[1] && (stat_b_reg != 8'hFF)) stat_b_reg <= stat_b_reg + 8'd1;
      if (cap_rsp && bus.alu_overflow && (stat_ovf_reg != 8'hFF)) begin
        stat_ovf_reg <= stat_ovf_reg + 8'd1;
      end
    end
  end

  assign stat_a_ops = stat_a_reg;
  assign stat_b_ops = stat_b_reg;
  assign stat_ovf   = stat_ovf_reg;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a behavioural 6-bit ALU on the alu_* side.
// Build with ALU_ARB_STATS_EN defined to also exercise the saturating counters.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.WIDTH(6)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [7:0] stat_a_ops, stat_b_ops, stat_ovf;
`endif

  alu_req_arbiter #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_a_ops (stat_a_ops),
    .stat_b_ops (stat_b_ops),
    .stat_ovf   (stat_ovf)
`endif
  );

  // Returns {overflow, cout, result}; 3'b110 is add, 3'b100 is subtract.
  function automatic logic [7:0] alu_model(input logic [5:0] x, input logic [5:0] y,
                                           input logic [2:0] f);
    logic [6:0] s;
    logic [5:0] r;
    logic       o, c;
    o = 1'b0;
    c = 1'b0;
    s = '0;
    case (f)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~x;
      3'd4: begin
        s = {1'b0, x} - {1'b0, y};
        r = s[5:0];
        c = s[6];
        o = (x[5] != y[5]) && (r[5] != x[5]);
      end
      3'd5: r = {x[4:0], 1'b0};
      3'd6: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[5:0];
        c = s[6];
        o = (x[5] == y[5]) && (r[5] != x[5]);
      end
      default: r = y;
    endcase
    return {o, c, r};
  endfunction

  always_comb begin
    {bus.alu_overflow, bus.alu_cout, bus.alu_sum} = alu_model(bus.alu_x, bus.alu_y, bus.alu_fxn);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Scoreboard entries: {port, overflow, cout, result}
  logic [8:0] sb [$];
  int         gl_port [$];
  int         gl_cyc [$];
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("ready_excl", {31'd0, (bus.a_req_ready & bus.b_req_ready) |
                           (bus.busy & (bus.a_req_ready | bus.b_req_ready))}, 0);
      check("rsp_excl", {31'd0, bus.a_rsp_valid & bus.b_rsp_valid}, 0);
      if (bus.a_req_ready) begin
        sb.push_back({1'b0, alu_model(bus.a_x, bus.a_y, bus.a_fxn)});
        gl_port.push_back(0);
        gl_cyc.push_back(cyc);
      end
      if (bus.b_req_ready) begin
        sb.push_back({1'b1, alu_model(bus.b_x, bus.b_y, bus.b_fxn)});
        gl_port.push_back(1);
        gl_cyc.push_back(cyc);
      end
      if ((bus.a_rsp_valid && bus.a_rsp_ready) || (bus.b_rsp_valid && bus.b_rsp_ready)) begin
        check("sb_nonempty", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("rsp port=%s result=%0d ovf=%0d cout=%0d", bus.b_rsp_valid ? "B" : "A",
                   bus.rsp_result, bus.rsp_overflow, bus.rsp_cout);
          check("rsp_port", {31'd0, bus.b_rsp_valid}, {31'd0, e[8]});
          check("rsp_ovf", {31'd0, bus.rsp_overflow}, {31'd0, e[7]});
          check("rsp_cout", {31'd0, bus.rsp_cout}, {31'd0, e[6]});
          check("rsp_result", {26'd0, bus.rsp_result}, {26'd0, e[5:0]});
        end
      end
    end
  end

  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid(input bit port, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (port ? bus.b_rsp_valid : bus.a_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_wait", {31'd0, ok}, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gl_port.delete();
    gl_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_bp;
    int         n;

    bus.a_req_valid = 0; bus.b_req_valid = 0;
    bus.a_x = 0; bus.a_y = 0; bus.a_fxn = 0;
    bus.b_x = 0; bus.b_y = 0; bus.b_fxn = 0;
    bus.a_rsp_ready = 0; bus.b_rsp_ready = 0;

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_req_ready", {30'd0, bus.a_req_ready, bus.b_req_ready}, 0);
    check("rst_rsp_valid", {30'd0, bus.a_rsp_valid, bus.b_rsp_valid}, 0);
    check("rst_alu", {17'd0, bus.alu_x, bus.alu_y, bus.alu_fxn}, 0);
    check("rst_rsp", {24'd0, bus.rsp_overflow, bus.rsp_cout, bus.rsp_result}, 0);
`ifdef ALU_ARB_STATS_EN
    check("rst_stats", {8'd0, stat_a_ops, stat_b_ops, stat_ovf}, 0);
`endif
    do_reset();

    // Single add from A: ready at cycle 0, response at cycle 2
    drive_step();
    bus.a_req_valid = 1; bus.a_x = 5; bus.a_y = 3; bus.a_fxn = 3'b110;
    @(negedge clk);
    check("add_a_ready", {31'd0, bus.a_req_ready}, 1);
    drive_step();
    bus.a_req_valid = 0;
    @(negedge clk);
    check("add_c1_valid", {31'd0, bus.a_rsp_valid}, 0);
    check("add_c1_busy", {31'd0, bus.busy}, 1);
    check("add_alu_ops", {17'd0, bus.alu_x, bus.alu_y, bus.alu_fxn}, {17'd0, 6'd5, 6'd3, 3'b110});
    @(negedge clk);
    check("add_c2_valid", {31'd0, bus.a_rsp_valid}, 1);
    check("add_result", {26'd0, bus.rsp_result}, 8);
    check("add_flags", {30'd0, bus.rsp_overflow, bus.rsp_cout}, 0);
    drive_step();
    bus.a_rsp_ready = 1;
    drive_step();
    bus.a_rsp_ready = 0;

    // Overflow from B
    bus.b_rsp_ready = 1;
    bus.b_req_valid = 1; bus.b_x = 31; bus.b_y = 1; bus.b_fxn = 3'b110;
    @(negedge clk);
    check("ovf_b_ready", {31'd0, bus.b_req_ready}, 1);
    drive_step();
    bus.b_req_valid = 0;
    wait_rsp_valid(1, 5);
    check("ovf_a_valid", {31'd0, bus.a_rsp_valid}, 0);
    check("ovf_result", {26'd0, bus.rsp_result}, 32);
    check("ovf_flags", {30'd0, bus.rsp_overflow, bus.rsp_cout}, 2);
    drive_step();
    bus.b_rsp_ready = 0;

    // Contention after reset: A, B, A, B, three cycles apart
    do_reset();
    drive_step();
    bus.a_rsp_ready = 1; bus.b_rsp_ready = 1;
    bus.a_req_valid = 1; bus.a_x = 10; bus.a_y = 20; bus.a_fxn = 3'b110;
    bus.b_req_valid = 1; bus.b_x = 7;  bus.b_y = 9;  bus.b_fxn = 3'b100;
    repeat (10) @(posedge clk);
    #1;
    bus.a_req_valid = 0; bus.b_req_valid = 0;
    repeat (4) drive_step();
    check("cont_grants", gl_port.size(), 4);
    if (gl_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("cont_port%0d", i), gl_port[i], i % 2);
        if (i > 0) check($sformatf("cont_gap%0d", i), gl_cyc[i] - gl_cyc[i-1], 3);
      end
    end

    // Back-pressure on A while B waits
    bus.a_rsp_ready = 0; bus.b_rsp_ready = 1;
    bus.a_req_valid = 1; bus.a_x = 12; bus.a_y = 9; bus.a_fxn = 3'b010;
    exp_bp = alu_model(6'd12, 6'd9, 3'b010);
    @(negedge clk);
    check("bp_a_ready", {31'd0, bus.a_req_ready}, 1);
    drive_step();
    bus.a_req_valid = 0;
    bus.b_req_valid = 1; bus.b_x = 20; bus.b_y = 3; bus.b_fxn = 3'b110;
    wait_rsp_valid(0, 5);
    for (int i = 0; i < 4; i++) begin
      check("bp_a_valid", {31'd0, bus.a_rsp_valid}, 1);
      check("bp_result", {26'd0, bus.rsp_result}, {26'd0, exp_bp[5:0]});
      check("bp_b_ready", {31'd0, bus.b_req_ready}, 0);
      drive_step();
      @(negedge clk);
    end
    drive_step();
    bus.a_rsp_ready = 1;
    @(negedge clk);
    check("bp_b_ready_hs", {31'd0, bus.b_req_ready}, 0);
    @(negedge clk);
    check("bp_b_grant", {31'd0, bus.b_req_ready}, 1);
    drive_step();
    bus.b_req_valid = 0;
    wait_rsp_valid(1, 5);
    drive_step();

    // Reset asserted during EXEC
    bus.a_req_valid = 1; bus.a_x = 9; bus.a_y = 4; bus.a_fxn = 3'b110;
    @(negedge clk);
    check("rx_a_ready", {31'd0, bus.a_req_ready}, 1);
    drive_step();
    bus.a_req_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rx_busy", {31'd0, bus.busy}, 0);
    check("rx_rsp_valid", {30'd0, bus.a_rsp_valid, bus.b_rsp_valid}, 0);
    check("rx_alu", {17'd0, bus.alu_x, bus.alu_y, bus.alu_fxn}, 0);
    check("rx_rsp", {24'd0, bus.rsp_overflow, bus.rsp_cout, bus.rsp_result}, 0);
    repeat (3) begin
      @(negedge clk);
      check("rx_hold", {29'd0, bus.busy, bus.a_rsp_valid, bus.b_rsp_valid}, 0);
    end
    drive_step();
    rst_n = 1'b1;
    gl_port.delete();
    gl_cyc.delete();

    // History cleared by reset: A wins the first contest again
    bus.a_req_valid = 1; bus.a_x = 2; bus.a_y = 2; bus.a_fxn = 3'b110;
    bus.b_req_valid = 1; bus.b_x = 1; bus.b_y = 1; bus.b_fxn = 3'b110;
    @(negedge clk);
    check("rx_first_win", {30'd0, bus.a_req_ready, bus.b_req_ready}, 2);
    drive_step();
    bus.a_req_valid = 0; bus.b_req_valid = 0;
    wait_rsp_valid(0, 5);
    drive_step();
    drive_step();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    bus.a_rsp_ready = 1;
    bus.a_req_valid = 1; bus.a_x = 31; bus.a_y = 1; bus.a_fxn = 3'b110;
    n = 0;
    for (int i = 0; i < 1200 && n < 300; i++) begin
      @(negedge clk);
      if (bus.a_req_ready) n++;
    end
    drive_step();
    bus.a_req_valid = 0;
    repeat (4) drive_step();
    check("st_ops_done", n, 300);
    check("st_a_ops", {24'd0, stat_a_ops}, 255);
    check("st_ovf", {24'd0, stat_ovf}, 255);
    check("st_b_ops", {24'd0, stat_b_ops}, 0);
`else
    n = 0;
`endif

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-port round-robin arbiter and sequencer for the team's shared 6-bit combinational ALU (8 functions selected by a 3-bit code). Each requester presents operands and a function code with a valid/ready handshake. The block grants one request at a time and drives the ALU from registered operands. It captures result, overflow and carry-out into a response register, then holds them until the granted requester accepts. It sits between the control logic of two client blocks and the single ALU instance.

## Interface
- `WIDTH`, 6: operand/result width; must match the ALU.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `a_req_valid`, `b_req_valid` input 1 each: requester has an operation pending.
- `a_req_ready`, `b_req_ready` output 1 each: request accepted this cycle.
- `a_x`, `a_y`, `b_x`, `b_y` input WIDTH each: operands.
- `a_fxn`, `b_fxn` input 3 each: ALU function code.
- `a_rsp_valid`, `b_rsp_valid` output 1 each: response available for that requester.
- `a_rsp_ready`, `b_rsp_ready` input 1 each: requester consumes the response.
- `rsp_result` output WIDTH: shared response data.
- `rsp_overflow`, `rsp_cout` output 1 each: shared response flags.
- `alu_x`, `alu_y` output WIDTH each: registered operands to the ALU.
- `alu_fxn` output 3: registered function code to the ALU.
- `alu_sum` input WIDTH: ALU result.
- `alu_overflow`, `alu_cout` input 1 each: ALU flags.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `*_req_valid` is high, pick a winner, assert that port's `*_req_ready` (combinational, same cycle), and latch its x/y/fxn into the `alu_*` registers.
  - Record the winner in `owner`, update `last_grant`, and go to EXEC.
- EXEC (exactly one cycle): capture `alu_sum`, `alu_overflow` and `alu_cout` into the response registers, then go to RESP.
- RESP:
  - Assert only the owner's `*_rsp_valid`.
  - On the owner's `*_rsp_ready`, clear valid and go to IDLE.
  - The non-owner's `rsp_ready` is ignored.
- Arbitration:
  - Only one valid: that port wins.
  - Both valid: the port not equal to `last_grant` wins.
  - `last_grant` resets to B, so A wins the first contest.
- `*_req_ready` is never asserted outside IDLE, and never to both ports in the same cycle.
- Requests stay pending, and requesters must hold valid and operands, until ready is asserted.
- `alu_*` registers hold their value after EXEC.
- `rsp_result`, `rsp_overflow` and `rsp_cout` stay stable throughout RESP.
- No arithmetic is done in this block. Widths pass through unchanged, and overflow/carry are taken from the ALU verbatim.

## Timing
- Reset values:
  - state IDLE; `owner`=A; `last_grant`=B.
  - All `*_req_ready`, `*_rsp_valid` and `busy` = 0.
  - `alu_x`, `alu_y`, `alu_fxn`, `rsp_result` = 0; `rsp_overflow`, `rsp_cout` = 0.
- Latency: accept at cycle N, EXEC at N+1, `rsp_valid` high from N+2.
- Throughput: minimum 3 cycles per operation (accept, exec, resp with `rsp_ready` already high). The next accept is earliest at N+3.
- Back-pressure: if `rsp_ready` is low, RESP holds indefinitely and no new grant is issued.
- Reset asserted mid-operation: the operation is aborted with no response. All outputs immediately take their reset values, and arbitration history is cleared.
- A request that drops valid before being accepted is simply not served; no error is raised.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Adds 8-bit saturating counters `stat_a_ops` and `stat_b_ops`, incremented on each accepted request.
  - Adds an 8-bit saturating counter `stat_ovf`, incremented in EXEC when `alu_overflow`=1.
  - All three are output ports, reset to 0, and stick at 255.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- Single add: A requests x=5, y=3, fxn=110 at cycle 0. Required: `a_req_ready`=1 at cycle 0, `a_rsp_valid`=1 at cycle 2, `rsp_result`=8, `rsp_overflow`=0, `rsp_cout`=0.
- Overflow: B requests x=31, y=1, fxn=110. Required: `rsp_result`=32, `rsp_overflow`=1, `rsp_cout`=0, and `b_rsp_valid` only (`a_rsp_valid` stays 0).
- Contention: after reset, A and B both hold valid continuously. Required: grant order A, B, A, B, with accepts 3 cycles apart while `rsp_ready`=1.
- Back-pressure: hold `a_rsp_ready`=0 for 4 cycles while B is valid. Required: `a_rsp_valid` and the result stay stable, `b_req_ready`=0 throughout, and B is granted the cycle after `a_rsp_ready` rises.
- Reset mid-EXEC: assert `rst_n`=0 during EXEC. Required: `busy`=0, no `rsp_valid`, and all outputs return to reset values asynchronously.
- `ALU_ARB_STATS_EN`: 300 A operations with x=31, y=1, fxn=110. Required: `stat_a_ops`=255, `stat_ovf`=255, `stat_b_ops`=0.
